// File: rtl/instr_encoder_loader_pkg.sv
// Shared opcode constants, descriptor kinds and loader FSM states for the
// MIPS encoder/loader and the main decoder.
package instr_encoder_loader_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [2:0] {
        K_RTYPE = 3'd0,
        K_LW    = 3'd1,
        K_SW    = 3'd2,
        K_BEQ   = 3'd3,
        K_ADDI  = 3'd4,
        K_J     = 3'd5
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: descriptor kind plus fields -> 32-bit MIPS word.
// Kinds 6 and 7 raise illegal_o and produce an all-zero word.
module instr_pack
    import instr_encoder_loader_pkg::*;
(
    input  logic [2:0]  kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (kind_i)
            K_RTYPE: word_o = {OP_RTYPE, rs_i, rt_i, rd_i, shamt_i, funct_i};
            K_LW:    word_o = {OP_LW,    rs_i, rt_i, imm_i};
            K_SW:    word_o = {OP_SW,    rs_i, rt_i, imm_i};
            K_BEQ:   word_o = {OP_BEQ,   rs_i, rt_i, imm_i};
            K_ADDI:  word_o = {OP_ADDI,  rs_i, rt_i, imm_i};
            K_J:     word_o = {OP_J,     target_i};
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts instruction descriptors over valid/ready, packs them and writes
// them to imem one word per cycle, starting at word 0 of each session.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int AW   = 6,
    parameter int MAXW = 2**AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [2:0]    kind,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [4:0]    shamt,
    input  logic [5:0]    funct,
    input  logic [15:0]   imm,
    input  logic [25:0]   target,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wd,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [AW:0] MAXC = (AW+1)'(MAXW);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    state_e        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wd_q, wd_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [31:0]   word;
    logic          illegal;
    logic          ready;
    logic          accept;

    instr_pack u_pack (
        .kind_i    (kind),
        .rs_i      (rs),
        .rt_i      (rt),
        .rd_i      (rd),
        .shamt_i   (shamt),
        .funct_i   (funct),
        .imm_i     (imm),
        .target_i  (target),
        .word_o    (word),
        .illegal_o (illegal)
    );

    assign accept = in_valid & ready;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // accept already implies start=0, so a restart never collides with an end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: if (accept && (in_last || (!illegal && (count_q + ONE) == MAXC)))
                         state_d = ST_DONE;
            ST_DONE: if (start) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == ST_LOAD) && (count_q < MAXC) && !start;
        busy  = (state_q == ST_LOAD) || we_q;
        done  = (state_q == ST_DONE) && !we_q;
    end

    // A write already on the outputs is unaffected by a restart
    always_comb begin
        we_d    = accept & ~illegal;
        addr_d  = addr_q;
        wd_d    = wd_q;
        count_d = count_q;
        err_d   = err_q;
        if (we_d) begin
            addr_d  = count_q[AW-1:0];
            wd_d    = word;
            count_d = count_q + ONE;
        end
        if (start)                  begin count_d = '0; err_d = 1'b0; end
        else if (accept && illegal) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = ready;
    assign imem_we   = we_q;
    assign imem_addr = addr_q;
    assign imem_wd   = wd_q;
    assign count     = count_q;
    assign err       = err_q;

endmodule
